// File: rtl/io_port_ctrl.sv
// -----------------------------------------------------------------------------
// io_port_ctrl
//   I/O port controller that sits next to the 8-bit pipelined core.
//   Output path: core writes go into a small show-ahead FIFO. The FIFO drains
//   to an external valid/ready sink.
//   Input path: a one-byte holding register is loaded from an external
//   valid/ready source. The core is interrupted when a byte arrives.
//
// Optional feature macro: IO_IRQ_LEVEL_EN
//   defined   : interrupt is a registered level, high while a byte is held.
//   undefined : interrupt is a one-cycle pulse after each capture (default).
//
// Ports:
//   clk, reset      clock (rising edge) and synchronous active-high reset
//   cpu_data_out    byte written by the core, qualified by cpu_wr
//   cpu_wr          core write strobe
//   cpu_rd          core acknowledge that cpu_data_in has been consumed
//   cpu_data_in     held input byte presented to the core
//   interrupt       interrupt to the core
//   ext_in_*        external source handshake (data/valid in, ready out)
//   ext_out_*       external sink handshake (data/valid out, ready in)
//   out_full        output FIFO holds DEPTH entries
//   out_empty       output FIFO holds no entries
//   overflow        sticky: a core write was dropped because the FIFO was full
//   dbg_in_state    input FSM state (0 = EMPTY, 1 = FULL)
//
// Handshake rule on both external ports: a byte transfers on a rising edge
// where valid and ready are both 1. A source holds valid and data stable until
// that edge. ready may depend on state only, never combinationally on valid.
// -----------------------------------------------------------------------------
module io_port_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    output logic [DATA_W-1:0] cpu_data_in,
    output logic              interrupt,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic              out_full,
    output logic              out_empty,
    output logic              overflow,
    output logic              dbg_in_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // ---------------- output FIFO ----------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic              w_push;
    logic              w_pop;

    assign out_full      = (r_count == CNT_FULL);
    assign out_empty     = (r_count == '0);
    assign ext_out_valid = !out_empty;
    assign ext_out_data  = r_mem[r_rd_ptr];
    assign overflow      = r_overflow;

    assign w_pop  = ext_out_valid && ext_out_ready;
    // A pop in the same cycle frees a slot, so a write to a full FIFO is
    // still accepted when the sink is draining.
    assign w_push = cpu_wr && (!out_full || w_pop);

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cpu_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (cpu_wr && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------- input holding register ----------------
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } in_state_t;

    in_state_t         r_state;
    in_state_t         w_next_state;
    logic              w_capture;
    logic [DATA_W-1:0] r_data_in;
    logic              r_irq;

    assign ext_in_ready = (r_state == S_EMPTY);
    assign cpu_data_in  = r_data_in;
    assign interrupt    = r_irq;
    assign dbg_in_state = (r_state == S_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // An acknowledge in FULL only returns to EMPTY. A waiting source byte is
    // taken on the next cycle, when ready is 1 again. There is no bypass.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (ext_in_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_FULL;
                end
            end
            S_FULL: begin
                if (cpu_rd) begin
                    w_next_state = S_EMPTY;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    // The held byte is not cleared on acknowledge. It keeps its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_in <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data_in <= ext_in_data;
            end
`ifdef IO_IRQ_LEVEL_EN
            r_irq <= (w_next_state == S_FULL);
`else
            r_irq <= w_capture;
`endif
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_io_port_ctrl
//   Self-checking bench for io_port_ctrl. A behavioural model holds the output
//   FIFO as a queue of expected bytes and the input side as a held byte plus an
//   occupied flag. After every clock edge, each DUT output is compared against
//   the model. Directed sequences are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_io_port_ctrl;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic [DATA_W-1:0] cpu_data_out = '0;
    logic              cpu_wr = 1'b0;
    logic              cpu_rd = 1'b0;
    logic [DATA_W-1:0] ext_in_data = '0;
    logic              ext_in_valid = 1'b0;
    logic              ext_out_ready = 1'b0;
    logic [DATA_W-1:0] cpu_data_in;
    logic              interrupt;
    logic              ext_in_ready;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              out_full;
    logic              out_empty;
    logic              overflow;
    logic              dbg_in_state;

    io_port_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_data_out  (cpu_data_out),
        .cpu_wr        (cpu_wr),
        .cpu_rd        (cpu_rd),
        .cpu_data_in   (cpu_data_in),
        .interrupt     (interrupt),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .out_full      (out_full),
        .out_empty     (out_empty),
        .overflow      (overflow),
        .dbg_in_state  (dbg_in_state)
    );

    // ---------------- scoreboard / model state ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic              m_overflow;
    logic [DATA_W-1:0] m_held;
    logic              m_in_full;
    logic              m_irq;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit pop;
        bit full;
        bit captured;
        if (reset) begin
            exp_q.delete();
            m_overflow = 1'b0;
            m_held     = '0;
            m_in_full  = 1'b0;
            m_irq      = 1'b0;
        end else begin
            full = (exp_q.size() == DEPTH);
            pop  = (exp_q.size() > 0) && ext_out_ready;
            if (pop) void'(exp_q.pop_front());
            if (cpu_wr) begin
                if (!full || pop) exp_q.push_back(cpu_data_out);
                else m_overflow = 1'b1;
            end
            captured = 1'b0;
            if (!m_in_full) begin
                if (ext_in_valid) begin
                    m_held    = ext_in_data;
                    m_in_full = 1'b1;
                    captured  = 1'b1;
                end
            end else if (cpu_rd) begin
                m_in_full = 1'b0;
            end
`ifdef IO_IRQ_LEVEL_EN
            m_irq = m_in_full;
`else
            m_irq = captured;
`endif
        end
    endtask

    task automatic compare_all();
        check_val("out_empty", out_empty, (exp_q.size() == 0));
        check_val("out_full", out_full, (exp_q.size() == DEPTH));
        check_val("ext_out_valid", ext_out_valid, (exp_q.size() != 0));
        if (exp_q.size() != 0) check_val("ext_out_data", ext_out_data, exp_q[0]);
        check_val("overflow", overflow, m_overflow);
        check_val("cpu_data_in", cpu_data_in, m_held);
        check_val("ext_in_ready", ext_in_ready, !m_in_full);
        check_val("dbg_in_state", dbg_in_state, m_in_full);
        check_val("interrupt", interrupt, m_irq);
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit wr, input logic [DATA_W-1:0] wdata, input bit rd,
                         input bit ivalid, input logic [DATA_W-1:0] idata, input bit oready);
        cpu_wr        = wr;
        cpu_data_out  = wdata;
        cpu_rd        = rd;
        ext_in_valid  = ivalid;
        ext_in_data   = idata;
        ext_out_ready = oready;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] last;

        // Reset state
        do_reset();
        check_val("rst_out_empty", out_empty, 1'b1);
        check_val("rst_in_ready", ext_in_ready, 1'b1);
        check_val("rst_irq", interrupt, 1'b0);
        check_val("rst_ovf", overflow, 1'b0);
        check_val("rst_data_in", cpu_data_in, 8'h00);

        // FIFO order with a held sink, then a dropped write
        for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(8'h11 * i), 1'b0, 1'b0, '0, 1'b0);
        check_val("fill_full", out_full, 1'b1);
        check_val("fill_head", ext_out_data, 8'h11);
        cycle(1'b1, 8'h55, 1'b0, 1'b0, '0, 1'b0);
        check_val("drop_ovf", overflow, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check_val("drain_order", ext_out_data, DATA_W'(8'h11 * i));
            cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        end
        check_val("drain_empty", out_empty, 1'b1);

        // Write to a full FIFO while it drains is accepted
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0, '0, 1'b1);
        check_val("full_rw_full", out_full, 1'b1);
        check_val("full_rw_ovf", overflow, 1'b0);
        last = '0;
        for (int i = 0; i < 4; i++) begin
            last = ext_out_data;
            cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        end
        check_val("full_rw_last", last, 8'h66);

        // Input capture, hold-off and re-capture
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 8'hA5, 1'b0);
        check_val("cap_data", cpu_data_in, 8'hA5);
        check_val("cap_ready", ext_in_ready, 1'b0);
        check_val("cap_irq", interrupt, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 8'h5A, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 8'h5A, 1'b0);
        check_val("ack_keep", cpu_data_in, 8'hA5);
        check_val("ack_ready", ext_in_ready, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 8'h5A, 1'b0);
        check_val("recap_data", cpu_data_in, 8'h5A);
        check_val("recap_irq", interrupt, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

        // Pointer wrap with continuous streaming
        for (int i = 0; i < 10; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        check_val("wrap_empty", out_empty, 1'b1);
        check_val("wrap_ovf", overflow, 1'b0);

`ifdef IO_IRQ_LEVEL_EN
        // Level interrupt held until acknowledge
        cycle(1'b0, '0, 1'b0, 1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_val("lvl_high", interrupt, 1'b1);
            cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check_val("lvl_fall", interrupt, 1'b0);
`endif

        // Randomized traffic on both paths, with occasional reset
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            cycle(1'b1 & ($urandom_range(0, 2) != 0), DATA_W'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                  DATA_W'($urandom), ($urandom_range(0, 2) == 0));
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
I/O port controller next to the 8-bit pipelined processor core. It feeds the core's data_in and interrupt inputs and consumes the core's data_out.
- Output path: bytes written by the core go into a small FIFO, which drains to an external valid/ready sink.
- Input path: one byte from an external valid/ready source is held in a register, and the core is interrupted when it arrives.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- DATA_W, 8, data width; matches the core datapath.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_data_out  input  DATA_W  byte from the core's data_out.
- cpu_wr  input  1  core write strobe; qualifies cpu_data_out.
- cpu_rd  input  1  core acknowledge that cpu_data_in has been consumed.
- cpu_data_in  output  DATA_W  held input byte; drives the core's data_in.
- interrupt  output  1  drives the core's interrupt input.
- ext_in_data  input  DATA_W  external source byte.
- ext_in_valid  input  1  external source valid.
- ext_in_ready  output  1  controller can accept an input byte.
- ext_out_data  output  DATA_W  head of the output FIFO.
- ext_out_valid  output  1  output FIFO is not empty.
- ext_out_ready  input  1  external sink accepts the byte.
- out_full  output  1  output FIFO holds DEPTH entries.
- out_empty  output  1  output FIFO holds 0 entries.
- overflow  output  1  sticky flag: a core write was dropped.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- While reset is high:
  - FIFO pointers and count go to 0.
  - Input FSM goes to EMPTY.
  - cpu_data_in = 0, interrupt = 0, overflow = 0.
  - Resulting outputs: ext_out_valid = 0, out_empty = 1, out_full = 0, ext_in_ready = 1.
- Reset mid-operation discards FIFO contents and the held byte; nothing drains afterwards.

Output FIFO:
- count is clog2(DEPTH)+1 bits; read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- pop = ext_out_valid && ext_out_ready.
- push = cpu_wr && (!out_full || pop).
  - When full, a simultaneous pop frees a slot and the push is accepted.
- Dropped write: cpu_wr && out_full && !pop. The data is discarded and overflow is set; overflow stays set until reset.
- Show-ahead read:
  - ext_out_data = mem[rd_ptr] whenever ext_out_valid = 1.
  - ext_out_data holds stable while valid && !ready.
- Latency: a byte pushed at edge N gives ext_out_valid = 1 after edge N. First-word fall-through is one cycle.
- Push and pop together at count 0 cannot happen, because pop requires valid.
- Push and pop together at 0 < count < DEPTH: count is unchanged and both pointers advance.
- out_full = (count == DEPTH); out_empty = (count == 0); ext_out_valid = !out_empty. All are derived from registered count.

Input FSM, states EMPTY and FULL:
- ext_in_ready = (state == EMPTY), decoded from state.
- EMPTY with ext_in_valid:
  - cpu_data_in <= ext_in_data.
  - Next state FULL.
  - interrupt <= 1 for exactly one cycle, the cycle after the capture edge.
- FULL with cpu_rd: next state EMPTY. cpu_data_in keeps its last value and is not cleared.
- FULL with ext_in_valid: no capture, because ready is 0. The source must hold its data.
- FULL with cpu_rd and ext_in_valid in the same cycle: go to EMPTY. The capture happens on the following cycle, so there is no same-cycle bypass.
- cpu_rd while EMPTY is ignored.
- Independence: the output and input paths share no state, and simultaneous activity on both is fully independent.

Optional Feature:
Macro IO_IRQ_LEVEL_EN.
- Defined: interrupt is a registered level. It is 1 for every cycle the FSM is in FULL, rising the cycle after capture and falling the cycle after the cpu_rd acknowledge.
- Undefined (default): interrupt is the single-cycle pulse described above.

Test Plan:
1. Reset, then check outputs: out_empty = 1, ext_in_ready = 1, interrupt = 0, overflow = 0, cpu_data_in = 0x00.
2. FIFO order: hold ext_out_ready = 0 and write 0x11, 0x22, 0x33, 0x44 -> out_full = 1, ext_out_data = 0x11. Write 0x55 -> overflow = 1 and the byte is dropped. Raise ready -> 0x11, 0x22, 0x33, 0x44 drain on consecutive cycles, then out_empty = 1.
3. Full FIFO with ready = 1 and cpu_wr = 0x66 in the same cycle -> the write is accepted, count stays 4, overflow is unchanged, and 0x66 emerges last.
4. Input capture: ext_in_valid with 0xA5 while EMPTY -> next cycle cpu_data_in = 0xA5, ext_in_ready = 0, and interrupt pulses for 1 cycle. A second byte 0x5A is held off until cpu_rd; it is captured one cycle after EMPTY is re-entered and interrupt pulses again.
5. Pointer wrap: stream 10 bytes 0x00 to 0x09 with ready = 1 and one write per cycle -> output order is preserved across pointer wrap and overflow stays 0.
6. With IO_IRQ_LEVEL_EN defined, capture 0x3C and wait 5 cycles, then cpu_rd -> interrupt is high for all 5 cycles and falls the cycle after cpu_rd.
